// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default geometry plus binary/Gray pointer conversions.
// Used by both the write-pointer and read-pointer blocks so that both domains
// agree on pointer width and encoding.
package fifo_pkg;

   localparam int FIFO_PTR_WIDTH  = 9;
   localparam int FIFO_DEPTH      = 1 << FIFO_PTR_WIDTH;
   localparam int FIFO_DATA_WIDTH = 32;

   // Conversions operate on a fixed wide word; callers zero-extend their
   // pointer in and cast the result back down. Zero-extension is transparent
   // to both conversions, so any pointer width up to GRAY_MAX_W works.
   localparam int GRAY_MAX_W = 32;
   typedef logic [GRAY_MAX_W-1:0] gray_word_t;

   function automatic gray_word_t bin2gray(input gray_word_t b);
      return b ^ (b >> 1);
   endfunction

   function automatic gray_word_t gray2bin(input gray_word_t g);
      gray_word_t b;
      b[GRAY_MAX_W-1] = g[GRAY_MAX_W-1];
      for (int i = GRAY_MAX_W - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/sync_r2w.sv
// Two-flop synchronizer bringing the Gray read pointer into the wclk domain.
// Latency: 2 wclk edges from rptr_gray to rq2.
// No backpressure; samples every edge.
// Ports: wclk, wrst (sync, active-high), rptr_gray (async input), rq2 (synced output).
module sync_r2w
   import fifo_pkg::*;
#(
   parameter int PTR_WIDTH = FIFO_PTR_WIDTH
) (
   input  logic               wclk,
   input  logic               wrst,
   input  logic [PTR_WIDTH:0] rptr_gray,
   output logic [PTR_WIDTH:0] rq2
);

   logic [PTR_WIDTH:0] rq1;

   // Gray coding guarantees at most one bit is in flight per read-pointer
   // step, so a metastable first stage resolves to either old or new value.
   always_ff @(posedge wclk) begin
      if (wrst) begin
         rq1 <= '0;
         rq2 <= '0;
      end else begin
         rq1 <= rptr_gray;
         rq2 <= rq1;
      end
   end

endmodule

// File: rtl/wptr_full.sv
// Write-side pointer and status logic of an async FIFO (pointer, Gray pointer, full/almost-full, occupancy, overflow).
// Latency: status updates 1 wclk edge after a write; 3 edges after a read-pointer change.
// Backpressure: writes are ignored while wfull=1 and latch the sticky wovf flag.
// Ports: wclk, wrst (sync, active-high), write_enable, rptr_gray (async Gray read pointer),
//        wptr/wptr_gray (write pointers), wfull, walmost_full, wcount, wovf.
module wptr_full
   import fifo_pkg::*;
#(
   parameter int DEPTH        = FIFO_DEPTH,
   parameter int PTR_WIDTH    = FIFO_PTR_WIDTH,
   parameter int AFULL_THRESH = DEPTH - 4
) (
   input  logic               wclk,
   input  logic               wrst,
   input  logic               write_enable,
   input  logic [PTR_WIDTH:0] rptr_gray,
   output logic [PTR_WIDTH:0] wptr,
   output logic [PTR_WIDTH:0] wptr_gray,
   output logic               wfull,
   output logic               walmost_full,
   output logic [PTR_WIDTH:0] wcount,
   output logic               wovf
);

   localparam int PW1 = PTR_WIDTH + 1;
   localparam logic [PTR_WIDTH:0] AFULL_LVL = PW1'(AFULL_THRESH);

   logic [PTR_WIDTH:0] rq2;
   logic [PTR_WIDTH:0] rbin;
   logic [PTR_WIDTH:0] wbin_next;
   logic [PTR_WIDTH:0] wgray_next;
   logic [PTR_WIDTH:0] occ_next;
   logic               push;

   sync_r2w #(
      .PTR_WIDTH (PTR_WIDTH)
   ) u_sync_r2w (
      .wclk      (wclk),
      .wrst      (wrst),
      .rptr_gray (rptr_gray),
      .rq2       (rq2)
   );

   assign push       = write_enable & ~wfull;
   assign wbin_next  = wptr + PW1'(push);
   assign wgray_next = PW1'(bin2gray(gray_word_t'(wbin_next)));
   assign rbin       = PW1'(gray2bin(gray_word_t'(rq2)));
   // Next write pointer and the synced read pointer are combined in one
   // subtraction, so a write coinciding with an rq2 update is counted once.
   assign occ_next   = wbin_next - rbin;

   always_ff @(posedge wclk) begin
      if (wrst) begin
         wptr         <= '0;
         wptr_gray    <= '0;
         wfull        <= 1'b0;
         walmost_full <= 1'b0;
         wcount       <= '0;
         wovf         <= 1'b0;
      end else begin
         wptr         <= wbin_next;
         wptr_gray    <= wgray_next;
         // Full when the write pointer has lapped the read pointer exactly
         // once: in Gray code that is the top two bits inverted, rest equal.
         wfull        <= (wgray_next == {~rq2[PTR_WIDTH:PTR_WIDTH-1], rq2[PTR_WIDTH-2:0]});
         wcount       <= occ_next;
         walmost_full <= (occ_next >= AFULL_LVL);
         if (write_enable & wfull) begin
            wovf <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_wptr_full.sv
module tb_wptr_full;

   logic       clk = 1'b0;
   always #5 clk = ~clk;

   // DUT A: default geometry (512 entries)
   logic       rst_a = 1'b1, we_a = 1'b0;
   logic [9:0] rptr_gray_a = '0;
   logic [9:0] wptr_a, wptr_gray_a, wcount_a;
   logic       wfull_a, wafull_a, wovf_a;
   int         rp_a = 0;

   // DUT B: 8 entries, exercises pointer wrap
   logic       rst_b = 1'b1, we_b = 1'b0;
   logic [3:0] rptr_gray_b = '0;
   logic [3:0] wptr_b, wptr_gray_b, wcount_b;
   logic       wfull_b, wafull_b, wovf_b;
   int         rp_b = 0;

   wptr_full u_dut_a (
      .wclk(clk), .wrst(rst_a), .write_enable(we_a), .rptr_gray(rptr_gray_a),
      .wptr(wptr_a), .wptr_gray(wptr_gray_a), .wfull(wfull_a),
      .walmost_full(wafull_a), .wcount(wcount_a), .wovf(wovf_a)
   );

   wptr_full #(.DEPTH(8), .PTR_WIDTH(3)) u_dut_b (
      .wclk(clk), .wrst(rst_b), .write_enable(we_b), .rptr_gray(rptr_gray_b),
      .wptr(wptr_b), .wptr_gray(wptr_gray_b), .wfull(wfull_b),
      .walmost_full(wafull_b), .wcount(wcount_b), .wovf(wovf_b)
   );

   int n_chk = 0;
   int n_fail = 0;

   // Reference model: counts writes and the read position that has become
   // visible to the write side (2 edges of sync delay), occupancy by subtraction.
   int m_pw[2]  = '{9, 3};
   int m_thr[2] = '{508, 4};
   int m_w[2], m_h0[2], m_h1[2], m_occ[2], m_tot[2];
   bit m_full[2], m_afull[2], m_ovf[2];

   task automatic model_edge(input int d, input bit rst, input bit we, input int rp);
      int md, dp, rs;
      md = 1 << (m_pw[d] + 1);
      dp = 1 << m_pw[d];
      if (rst) begin
         m_w[d] = 0; m_h0[d] = 0; m_h1[d] = 0; m_occ[d] = 0; m_tot[d] = 0;
         m_full[d] = 0; m_afull[d] = 0; m_ovf[d] = 0;
      end else begin
         rs = m_h1[d];
         m_h1[d] = m_h0[d];
         m_h0[d] = rp;
         if (we && m_full[d]) m_ovf[d] = 1;
         if (we && !m_full[d]) begin
            m_w[d] = (m_w[d] + 1) % md;
            m_tot[d]++;
         end
         m_occ[d]   = (m_w[d] + md - rs) % md;
         m_full[d]  = (m_occ[d] == dp);
         m_afull[d] = (m_occ[d] >= m_thr[d]);
      end
   endtask

   task automatic tick();
      rptr_gray_a = 10'(rp_a ^ (rp_a >> 1));
      rptr_gray_b = 4'(rp_b ^ (rp_b >> 1));
      @(posedge clk);
      model_edge(0, rst_a, we_a, rp_a);
      model_edge(1, rst_b, we_b, rp_b);
      #1;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic check_model(input int d);
      if (d == 0) begin
         chk("A.wptr",   int'(wptr_a),      m_w[0]);
         chk("A.gray",   int'(wptr_gray_a), m_w[0] ^ (m_w[0] >> 1));
         chk("A.wfull",  int'(wfull_a),     int'(m_full[0]));
         chk("A.afull",  int'(wafull_a),    int'(m_afull[0]));
         chk("A.wcount", int'(wcount_a),    m_occ[0]);
         chk("A.wovf",   int'(wovf_a),      int'(m_ovf[0]));
      end else begin
         chk("B.wptr",   int'(wptr_b),      m_w[1]);
         chk("B.gray",   int'(wptr_gray_b), m_w[1] ^ (m_w[1] >> 1));
         chk("B.wfull",  int'(wfull_b),     int'(m_full[1]));
         chk("B.afull",  int'(wafull_b),    int'(m_afull[1]));
         chk("B.wcount", int'(wcount_b),    m_occ[1]);
         chk("B.wovf",   int'(wovf_b),      int'(m_ovf[1]));
      end
   endtask

   typedef struct {
      bit rst; bit we; int rp;
      int e_wptr; int e_wcount; bit e_full; bit e_ovf;
   } vec_t;
   vec_t tbl[12];

   initial begin
      int rd_cnt;
      int prev_w, prev_g;
      bit wrapped;

      // rst, we, rp(bin) -> wptr, wcount, wfull, wovf
      tbl[0]  = '{1, 1, 0, 0, 0, 0, 0};
      tbl[1]  = '{1, 1, 0, 0, 0, 0, 0};
      tbl[2]  = '{0, 1, 0, 1, 1, 0, 0};
      tbl[3]  = '{0, 1, 0, 2, 2, 0, 0};
      tbl[4]  = '{0, 0, 1, 2, 2, 0, 0};
      tbl[5]  = '{0, 0, 1, 2, 2, 0, 0};
      tbl[6]  = '{0, 0, 1, 2, 1, 0, 0};
      tbl[7]  = '{0, 1, 2, 3, 2, 0, 0};
      tbl[8]  = '{0, 1, 2, 4, 3, 0, 0};
      tbl[9]  = '{0, 0, 2, 4, 2, 0, 0};
      tbl[10] = '{1, 1, 2, 0, 0, 0, 0};
      tbl[11] = '{0, 1, 0, 1, 1, 0, 0};

      for (int i = 0; i < 12; i++) begin
         rst_a = tbl[i].rst; we_a = tbl[i].we; rp_a = tbl[i].rp;
         tick();
         chk($sformatf("tbl[%0d].wptr", i),   int'(wptr_a),   tbl[i].e_wptr);
         chk($sformatf("tbl[%0d].gray", i),   int'(wptr_gray_a),
             tbl[i].e_wptr ^ (tbl[i].e_wptr >> 1));
         chk($sformatf("tbl[%0d].wcount", i), int'(wcount_a), tbl[i].e_wcount);
         chk($sformatf("tbl[%0d].wfull", i),  int'(wfull_a),  int'(tbl[i].e_full));
         chk($sformatf("tbl[%0d].wovf", i),   int'(wovf_a),   int'(tbl[i].e_ovf));
      end

      // Fill 512 entries back-to-back with the read pointer parked at 0
      rst_a = 1; we_a = 1; rp_a = 0;
      tick(); tick();
      chk("rst.wptr", int'(wptr_a), 0);
      chk("rst.all",  int'({wptr_gray_a, wfull_a, wafull_a, wcount_a, wovf_a}), 0);
      rst_a = 0;
      for (int k = 1; k <= 512; k++) begin
         tick();
         if (k == 507) chk("afull@507", int'(wafull_a), 0);
         if (k == 508) chk("afull@508", int'(wafull_a), 1);
         if (k == 511) chk("full@511",  int'(wfull_a),  0);
      end
      chk("fill.wptr",   int'(wptr_a),      'h200);
      chk("fill.gray",   int'(wptr_gray_a), 'h300);
      chk("fill.wfull",  int'(wfull_a),     1);
      chk("fill.wcount", int'(wcount_a),    512);
      chk("fill.wovf",   int'(wovf_a),      0);

      // Write attempted while full
      tick();
      chk("ovf.wptr", int'(wptr_a), 'h200);
      chk("ovf.wovf", int'(wovf_a), 1);
      we_a = 0;
      tick();
      chk("ovf.sticky", int'(wovf_a), 1);

      // One read frees a slot: visible exactly 3 edges later
      rp_a = 1;
      tick(); chk("rd.full+1", int'(wfull_a), 1);
      tick(); chk("rd.full+2", int'(wfull_a), 1);
      tick(); chk("rd.full+3", int'(wfull_a), 0);
      chk("rd.wcount+3", int'(wcount_a), 511);
      chk("rd.ovf_kept", int'(wovf_a), 1);

      // Reset pulse mid-operation at occupancy 100
      rst_a = 1; rp_a = 0; tick();
      rst_a = 0; we_a = 1;
      for (int k = 0; k < 100; k++) tick();
      chk("mid.wcount", int'(wcount_a), 100);
      rst_a = 1; tick();
      chk("mid.rst.all", int'({wptr_a, wptr_gray_a, wfull_a, wafull_a, wcount_a, wovf_a}), 0);
      rst_a = 0; tick();
      chk("mid.first_wptr", int'(wptr_a), 1);

      // Random traffic on the 512-entry instance against the model
      rst_a = 1; tick();
      rst_a = 0; rd_cnt = 0;
      for (int c = 0; c < 2500; c++) begin
         we_a = ($urandom_range(0, 99) < 60);
         if (rd_cnt < m_tot[0] && $urandom_range(0, 99) < 50) rd_cnt++;
         rp_a = rd_cnt % 1024;
         tick();
         check_model(0);
      end

      // Random interleaved traffic on the 8-entry instance, watching the wrap
      rst_a = 1; rst_b = 1; we_a = 0; tick();
      rst_b = 0; rd_cnt = 0; wrapped = 0;
      prev_w = 0; prev_g = 0;
      for (int c = 0; c < 600; c++) begin
         we_b = ($urandom_range(0, 99) < 60);
         if (rd_cnt < m_tot[1] && $urandom_range(0, 99) < 50) rd_cnt++;
         rp_b = rd_cnt % 16;
         tick();
         check_model(1);
         if (wfull_b) chk("B.full_needs_8", int'(wcount_b), 8);
         if (prev_w == 15 && int'(wptr_b) == 0) begin
            wrapped = 1;
            chk("B.wrap.gray_from", prev_g, 4'b1000);
            chk("B.wrap.gray_to",   int'(wptr_gray_b), 0);
         end
         prev_w = int'(wptr_b);
         prev_g = int'(wptr_gray_b);
      end
      chk("B.wrap_seen", int'(wrapped), 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/wptr_full.md
WPTR_FULL -- requirements
Module: wptr_full

Interface
REQ-001 SHALL have parameter DEPTH, default 512, FIFO entries; power of two, equal to 2**PTR_WIDTH.
REQ-002 SHALL have parameter PTR_WIDTH, default 9, address bits; all pointers are PTR_WIDTH+1 bits wide.
REQ-003 SHALL have parameter AFULL_THRESH, default DEPTH-4, almost-full occupancy level.
REQ-004 SHALL have port wclk  input  1  write-domain clock; the block's only clock; all state on its rising edge.
REQ-005 SHALL have port wrst  input  1  reset, synchronous, active-high.
REQ-006 SHALL have port write_enable  input  1  write request from the producer.
REQ-007 SHALL have port rptr_gray  input  PTR_WIDTH+1  Gray-coded read pointer from the rclk domain, asynchronous to wclk.
REQ-008 SHALL have port wptr  output  PTR_WIDTH+1  registered binary write pointer to fifo_mem; the low PTR_WIDTH bits are the write address.
REQ-009 SHALL have port wptr_gray  output  PTR_WIDTH+1  registered Gray write pointer for the read domain.
REQ-010 SHALL have port wfull  output  1  registered full flag.
REQ-011 SHALL have port walmost_full  output  1  registered flag, set when occupancy >= AFULL_THRESH.
REQ-012 SHALL have port wcount  output  PTR_WIDTH+1  registered occupancy as seen from wclk; range 0..DEPTH.
REQ-013 SHALL have port wovf  output  1  sticky flag, set when a write is attempted while full.

Function
REQ-014 SHALL pass rptr_gray through two wclk flops (rq1, rq2) before any use.
REQ-015 SHALL define push = write_enable & !wfull; when push=0, wptr and wptr_gray hold.
REQ-016 SHALL compute wbin_next = wptr + push, modulo 2**(PTR_WIDTH+1), and wgray_next = (wbin_next>>1) ^ wbin_next; both register on the next edge.
REQ-017 SHALL register wfull <= (wgray_next == {~rq2[PTR_WIDTH:PTR_WIDTH-1], rq2[PTR_WIDTH-2:0]}).
REQ-018 SHALL register wcount <= wbin_next - gray2bin(rq2), modulo 2**(PTR_WIDTH+1).
REQ-019 SHALL register walmost_full <= (wbin_next - gray2bin(rq2)) >= AFULL_THRESH.
REQ-020 SHALL assert wfull on the edge that registers the DEPTH-th unread write, so it is visible the cycle after that write.
REQ-021 SHALL deassert wfull exactly 3 wclk edges after a stable rptr_gray change that frees space (2 sync stages + 1 register).
REQ-022 SHALL wrap wptr from 2**(PTR_WIDTH+1)-1 to 0, with a single-bit Gray transition and no false wfull.
REQ-023 SHALL set wovf when write_enable=1 and wfull=1; wovf clears only on reset; wptr does not advance on that cycle.
REQ-024 SHALL treat a write in the same cycle as an rq2 update as one combined wbin_next/rq2 evaluation; no write is lost or double-counted.

Reset
REQ-025 SHALL, on any wclk edge with wrst=1, load 0 into wptr, wptr_gray, wfull, walmost_full, wcount, wovf, rq1 and rq2, overriding write_enable.
REQ-026 SHALL, when wrst asserts mid-operation, show all outputs at 0 after the next edge; operation resumes on the first edge with wrst=0.

Structure
REQ-027 SHALL take DEPTH, PTR_WIDTH and DATA_WIDTH defaults, plus the bin2gray and gray2bin functions, from shared package fifo_pkg, which the read-pointer block also uses.
REQ-028 SHALL implement the two-flop synchronizer as sub-module sync_r2w (ports wclk, wrst, rptr_gray, rq2).

Verification
REQ-029 SHALL cover: wrst=1 for 2 cycles with write_enable=1 -> all outputs 0, wptr stays 0.
REQ-030 SHALL cover: rptr_gray=0 held, 512 back-to-back writes -> walmost_full=1 after write 508; after write 512 wptr=10'h200, wptr_gray=10'h300, wfull=1, wcount=512.
REQ-031 SHALL cover: wfull=1, write_enable=1 for 1 cycle -> wptr stays 10'h200, wovf=1 and stays 1 until wrst.
REQ-032 SHALL cover: while full, rptr_gray set to 10'h001 -> wfull=0 and wcount=511 exactly 3 cycles later.
REQ-033 SHALL cover: DEPTH=8, PTR_WIDTH=3, interleaved reads and writes -> wptr 4'hF->4'h0, wptr_gray 4'b1000->4'b0000, wfull never asserts with wcount<8.
REQ-034 SHALL cover: wrst pulsed at wcount=100 -> all outputs 0 next cycle; first write afterwards gives wptr=1.
